// File: rtl/traffic_light_cmd_tx.sv
// -----------------------------------------------------------------------------
// traffic_light_cmd_tx
//
// Host-side UART command transmitter for the traffic light override channel.
// 2-bit override requests arrive over a valid/ready handshake and are queued
// in a small FIFO. Each queued request is serialized as one ASCII character
// on the tx line: 00='G', 01='Y', 10='R', 11='X'. Frames are 8N1 by default.
// Frames follow each other with no idle gap while the FIFO holds entries.
//
// Build option:
//   TL_CMD_PARITY_EN - when defined, an even parity bit is sent after the data
//                      bits, making the frame 8E1 (11 bit times). The port list
//                      is the same in both builds.
//
// Parameters:
//   CLKS_PER_BIT - clk cycles per UART bit (>= 2)
//   FIFO_DEPTH   - command FIFO entries (power of two, >= 2)
//
// Ports:
//   clk        - system clock
//   rst_n      - asynchronous active-low reset
//   cmd_valid  - command request present
//   cmd_code   - 2-bit override code
//   cmd_ready  - FIFO can accept a command (combinational, not full)
//   tx         - serial output, idle high, registered
//   busy       - high while a frame is on the line, registered
//   fifo_count - current FIFO occupancy
// -----------------------------------------------------------------------------
module traffic_light_cmd_tx #(
    parameter int CLKS_PER_BIT = 104,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cmd_valid,
    input  logic [1:0]                    cmd_code,
    output logic                          cmd_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_ZERO  = BW'(0);
    localparam logic [BW-1:0] BAUD_ONE   = BW'(1);
    localparam logic [AW:0]   COUNT_FULL = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0]   COUNT_ZERO = (AW + 1)'(0);
    localparam logic [AW:0]   COUNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

`ifdef TL_CMD_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd4
    } state_t;
`endif

    // Maps an override code to the ASCII character sent on the line.
    function automatic logic [7:0] encode_cmd(input logic [1:0] code);
        logic [7:0] ch;
        case (code)
            2'b00:   ch = 8'h47;
            2'b01:   ch = 8'h59;
            2'b10:   ch = 8'h52;
            2'b11:   ch = 8'h58;
            default: ch = 8'h58;
        endcase
        return ch;
    endfunction

    // Even parity over a data byte (XOR of all bits).
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

    state_t          state_r;
    state_t          next_state_s;
    logic [1:0]      fifo_mem_r [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [AW:0]     count_r;
    logic [BW-1:0]   baud_cnt_r;
    logic [2:0]      bit_cnt_r;
    logic [7:0]      shift_r;
    logic            tx_r;
    logic            busy_r;
    logic            push_s;
    logic            pop_s;
    logic            baud_end_s;
    logic            fifo_empty_s;
    logic [7:0]      head_byte_s;
`ifdef TL_CMD_PARITY_EN
    logic            parity_r;
`endif

    assign cmd_ready    = (count_r != COUNT_FULL);
    assign push_s       = cmd_valid && cmd_ready;
    assign fifo_empty_s = (count_r == COUNT_ZERO);
    assign baud_end_s   = (baud_cnt_r == BAUD_LAST);
    assign head_byte_s  = encode_cmd(fifo_mem_r[rd_ptr_r]);
    assign tx           = tx_r;
    assign busy         = busy_r;
    assign fifo_count   = count_r;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state and pop decision; a pop happens only when leaving IDLE
    // or at the last STOP cycle, so back-to-back frames need no idle gap.
    always_comb begin
        next_state_s = state_r;
        pop_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s        = 1'b1;
                    next_state_s = ST_START;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (baud_end_s) begin
                    next_state_s = ST_DATA;
                end else begin
                    next_state_s = ST_START;
                end
            end
            ST_DATA: begin
                if (baud_end_s && (bit_cnt_r == 3'd7)) begin
`ifdef TL_CMD_PARITY_EN
                    next_state_s = ST_PARITY;
`else
                    next_state_s = ST_STOP;
`endif
                end else begin
                    next_state_s = ST_DATA;
                end
            end
`ifdef TL_CMD_PARITY_EN
            ST_PARITY: begin
                if (baud_end_s) begin
                    next_state_s = ST_STOP;
                end else begin
                    next_state_s = ST_PARITY;
                end
            end
`endif
            ST_STOP: begin
                if (baud_end_s && !fifo_empty_s) begin
                    pop_s        = 1'b1;
                    next_state_s = ST_START;
                end else if (baud_end_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_STOP;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Command FIFO: push gated only by full (checked before the pop), so a
    // simultaneous push and pop leaves the occupancy unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_r[i] <= 2'b00;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= COUNT_ZERO;
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= cmd_code;
                wr_ptr_r             <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + COUNT_ONE;
                2'b01:   count_r <= count_r - COUNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Serializer datapath: baud/bit counters, shift register and line driver.
    // tx is registered, so each bit value is launched on the edge that enters
    // its bit period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
            baud_cnt_r <= BAUD_ZERO;
            bit_cnt_r  <= 3'd0;
            shift_r    <= 8'h00;
`ifdef TL_CMD_PARITY_EN
            parity_r   <= 1'b0;
`endif
        end else if (pop_s) begin
            shift_r    <= head_byte_s;
`ifdef TL_CMD_PARITY_EN
            parity_r   <= even_parity(head_byte_s);
`endif
            tx_r       <= 1'b0;
            busy_r     <= 1'b1;
            baud_cnt_r <= BAUD_ZERO;
            bit_cnt_r  <= 3'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    tx_r       <= 1'b1;
                    busy_r     <= 1'b0;
                    baud_cnt_r <= BAUD_ZERO;
                end
                ST_START: begin
                    if (baud_end_s) begin
                        baud_cnt_r <= BAUD_ZERO;
                        bit_cnt_r  <= 3'd0;
                        tx_r       <= shift_r[0];
                    end else begin
                        baud_cnt_r <= baud_cnt_r + BAUD_ONE;
                    end
                end
                ST_DATA: begin
                    if (baud_end_s && (bit_cnt_r == 3'd7)) begin
                        baud_cnt_r <= BAUD_ZERO;
`ifdef TL_CMD_PARITY_EN
                        tx_r       <= parity_r;
`else
                        tx_r       <= 1'b1;
`endif
                    end else if (baud_end_s) begin
                        baud_cnt_r <= BAUD_ZERO;
                        bit_cnt_r  <= bit_cnt_r + 3'd1;
                        shift_r    <= {1'b0, shift_r[7:1]};
                        tx_r       <= shift_r[1];
                    end else begin
                        baud_cnt_r <= baud_cnt_r + BAUD_ONE;
                    end
                end
`ifdef TL_CMD_PARITY_EN
                ST_PARITY: begin
                    if (baud_end_s) begin
                        baud_cnt_r <= BAUD_ZERO;
                        tx_r       <= 1'b1;
                    end else begin
                        baud_cnt_r <= baud_cnt_r + BAUD_ONE;
                    end
                end
`endif
                ST_STOP: begin
                    // The pop case is handled above; here the line goes idle.
                    if (baud_end_s) begin
                        baud_cnt_r <= BAUD_ZERO;
                        busy_r     <= 1'b0;
                    end else begin
                        baud_cnt_r <= baud_cnt_r + BAUD_ONE;
                    end
                end
                default: begin
                    tx_r       <= 1'b1;
                    busy_r     <= 1'b0;
                    baud_cnt_r <= BAUD_ZERO;
                    bit_cnt_r  <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_traffic_light_cmd_tx.sv
// -----------------------------------------------------------------------------
// tb_traffic_light_cmd_tx
//
// Directed bench for traffic_light_cmd_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Accepted pushes enqueue the expected ASCII byte in a scoreboard; a line
// monitor decodes every frame on tx and compares it with the scoreboard head.
// Honours TL_CMD_PARITY_EN (expects an even parity bit and 11-bit frames).
// -----------------------------------------------------------------------------
module tb_traffic_light_cmd_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef TL_CMD_PARITY_EN
    localparam int FRAME_CYC = 11 * CPB;
`else
    localparam int FRAME_CYC = 10 * CPB;
`endif

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic [1:0] cmd_code;
    logic       cmd_ready;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_count;

    int n_checks    = 0;
    int n_errors    = 0;
    int frames_done = 0;
    int busy_cycles = 0;
    int busy_rises  = 0;
    int rst_events  = 0;
    logic busy_prev = 1'b0;
    logic [7:0] sb [$];

    traffic_light_cmd_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_code   (cmd_code),
        .cmd_ready  (cmd_ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Busy-time bookkeeping: high cycles and number of busy periods.
    always @(posedge clk) begin
        busy_prev <= busy;
        if (busy === 1'b1) busy_cycles <= busy_cycles + 1;
        if (busy === 1'b1 && busy_prev !== 1'b1) busy_rises <= busy_rises + 1;
    end

    always @(negedge rst_n) rst_events <= rst_events + 1;

    function automatic logic [7:0] ascii_of(input logic [1:0] code);
        case (code)
            2'b00:   return 8'h47;
            2'b01:   return 8'h59;
            2'b10:   return 8'h52;
            default: return 8'h58;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Holds a request until it is accepted (bounded), then records the
    // expected byte. Returns 1 time unit after the accepting edge.
    task automatic push(input logic [1:0] code);
        logic acc;
        int   k;
        acc = 1'b0;
        k   = 0;
        cmd_valid = 1'b1;
        cmd_code  = code;
        while (!acc && k < 500) begin
            acc = cmd_ready;
            @(posedge clk);
            #1;
            k++;
        end
        cmd_valid = 1'b0;
        check("push_accept", acc, 1'b1);
        if (acc) sb.push_back(ascii_of(code));
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        @(negedge clk);
        @(negedge clk);
        while (busy !== 1'b0 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check(tag, busy, 1'b0);
    endtask

    // Line monitor: decodes frames sampled 1.5 cycles into each bit.
    initial begin : monitor
        logic [7:0] rx_byte;
        logic [7:0] exp_byte;
        logic       start_bit;
        logic       stop_bit;
        logic       par_bit;
        int         rst_mark;
        rx_byte = 8'h00;
        par_bit = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx === 1'b0) begin
                rst_mark = rst_events;
                @(negedge clk);
                start_bit = tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    rx_byte[i] = tx;
                end
`ifdef TL_CMD_PARITY_EN
                repeat (CPB) @(negedge clk);
                par_bit = tx;
`endif
                repeat (CPB) @(negedge clk);
                stop_bit = tx;
                repeat (CPB - 2) @(negedge clk);
                if (rst_events == rst_mark) begin
                    frames_done++;
                    check("start_bit", start_bit, 1'b0);
                    check("stop_bit", stop_bit, 1'b1);
                    if (sb.size() == 0) begin
                        check("unexpected_frame", rx_byte, 8'hxx);
                    end else begin
                        exp_byte = sb.pop_front();
                        check("frame_byte", rx_byte, exp_byte);
`ifdef TL_CMD_PARITY_EN
                        check("parity_bit", par_bit, ^exp_byte);
`endif
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stimulus
        int rises0;
        int cyc0;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_code  = 2'b00;

        // Reset state, during and after reset.
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", cmd_ready, 1'b1);
        check("rst_count", fifo_count, 3'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_tx", tx, 1'b1);
        check("post_rst_count", fifo_count, 3'd0);

        // Single 'R': start bit on the edge after the push edge.
        rises0 = busy_rises;
        cyc0   = busy_cycles;
        @(posedge clk); #1;
        push(2'b10);
        @(negedge clk);
        check("single_pre_tx", tx, 1'b1);
        check("single_pre_count", fifo_count, 3'd1);
        @(negedge clk);
        check("single_start_tx", tx, 1'b0);
        check("single_busy", busy, 1'b1);
        check("single_post_count", fifo_count, 3'd0);
        wait_idle("single_idle");
        check("single_busy_len", busy_cycles - cyc0, FRAME_CYC);
        check("single_rises", busy_rises - rises0, 1);

        // Fill while a frame is on the line; a 5th request waits for a pop.
        repeat (5) @(negedge clk);
        rises0 = busy_rises;
        cyc0   = busy_cycles;
        @(posedge clk); #1;
        push(2'b10);
        push(2'b00);
        push(2'b01);
        push(2'b11);
        push(2'b10);
        @(negedge clk);
        check("full_count", fifo_count, 3'd4);
        check("full_ready", cmd_ready, 1'b0);
        @(posedge clk); #1;
        push(2'b01);
        @(negedge clk);
        check("refill_count", fifo_count, 3'd4);
        wait_idle("burst_idle");
        check("burst_busy_len", busy_cycles - cyc0, 6 * FRAME_CYC);
        check("burst_no_gap", busy_rises - rises0, 1);

        // Entry arrives at the start of the last STOP cycle: no gap.
        repeat (5) @(negedge clk);
        rises0 = busy_rises;
        cyc0   = busy_cycles;
        @(posedge clk); #1;
        push(2'b11);
        repeat (FRAME_CYC - 1) @(posedge clk);
        #1;
        push(2'b00);
        @(negedge clk);
        check("stop_last_tx", tx, 1'b1);
        check("stop_last_count", fifo_count, 3'd1);
        @(negedge clk);
        check("chain_start_tx", tx, 1'b0);
        check("chain_count", fifo_count, 3'd0);
        check("chain_busy", busy, 1'b1);
        wait_idle("chain_idle");
        check("chain_busy_len", busy_cycles - cyc0, 2 * FRAME_CYC);
        check("chain_rises", busy_rises - rises0, 1);

        // Reset during data bit 3 with two entries queued.
        repeat (5) @(negedge clk);
        @(posedge clk); #1;
        push(2'b10);
        push(2'b00);
        push(2'b01);
        check("mid_queued", fifo_count, 3'd2);
        repeat (15) @(posedge clk);
        #3;
        check("mid_bit3_tx", tx, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tx", tx, 1'b1);
        check("mid_rst_count", fifo_count, 3'd0);
        check("mid_rst_busy", busy, 1'b0);
        sb.delete();
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        rises0 = busy_rises;
        repeat (60) @(negedge clk);
        check("after_rst_tx", tx, 1'b1);
        check("after_rst_rises", busy_rises - rises0, 0);
        check("after_rst_count", fifo_count, 3'd0);

        // Single 'Y' (0x59, even parity 0 when enabled).
        rises0 = busy_rises;
        cyc0   = busy_cycles;
        @(posedge clk); #1;
        push(2'b01);
        wait_idle("y_idle");
        check("y_busy_len", busy_cycles - cyc0, FRAME_CYC);

        repeat (10) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        check("frames_total", frames_done, 10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
